// File: rtl/train_pkg.sv
// Shared definitions for the DNN-array training sequencer.
// State encoding and default pipeline timing.
package train_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        UPDATE,
        DONE
    } state_t;

    localparam int FWD_LAT_DEF  = 4;
    localparam int LOAD_OFS_DEF = 2;

endpackage

// File: rtl/cnt_mod.sv
// Generic wrapping up-counter: counts 0..term, tc flags the terminal value.
// Wraps to 0 when enabled at the terminal value.
module cnt_mod #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] q,
    output logic         tc
);

    assign tc = (q == term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= tc ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/train_ctrl.sv
// Training sequencer: walks the sample ROM in mini-batches for a set
// number of epochs, pulsing the array's load/accu/wr/rst_btch controls.
module train_ctrl
    import train_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 16,
    parameter int FWD_LAT  = FWD_LAT_DEF,
    parameter int LOAD_OFS = LOAD_OFS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   i_n_smpl,
    input  logic [ADDR_W:0]   i_n_batch,
    input  logic [CNT_W-1:0]  i_n_epoch,
    output logic [ADDR_W-1:0] o_addr,
    output logic              load,
    output logic              accu,
    output logic              wr,
    output logic              rst_btch,
    output logic              smpl_vld,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  o_epoch
);

    localparam int PH_W = $clog2(FWD_LAT + 1);

    state_t st, nxt;

    logic [ADDR_W:0]  n_smpl, n_batch;
    logic [CNT_W-1:0] n_epoch, epoch;
    logic [PH_W-1:0]  ph_q;
    logic [ADDR_W:0]  b_q, s_q;
    logic             ph_tc, b_tc, s_tc;
    logic             go, zero, in_run, accu_i, ep_end, last_ep;
    logic             unused_b;

    assign zero    = (i_n_smpl == '0) || (i_n_batch == '0) ||
                     (i_n_epoch == '0);
    assign go      = (st == IDLE) && start && !abort;
    assign in_run  = (st == RUN);
    assign accu_i  = in_run && ph_tc;
    assign ep_end  = (s_q == '0);
    assign last_ep = (epoch == n_epoch - CNT_W'(1));
    assign unused_b = ^b_q;

    always_comb begin
        nxt = st;
        unique case (st)
            IDLE:    if (start) nxt = zero ? DONE : CLEAR;
            CLEAR:   nxt = RUN;
            RUN:     if (accu_i && (b_tc || s_tc)) nxt = UPDATE;
            UPDATE:  nxt = (ep_end && last_ep) ? DONE : CLEAR;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    // counts are frozen at start so the host may reprogram them freely
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_smpl  <= '0;
            n_batch <= '0;
            n_epoch <= '0;
            epoch   <= '0;
        end else if (go) begin
            n_smpl  <= i_n_smpl;
            n_batch <= i_n_batch;
            n_epoch <= i_n_epoch;
            epoch   <= '0;
        end else if (st == UPDATE && !abort && ep_end && !last_ep) begin
            epoch <= epoch + CNT_W'(1);
        end
    end

    cnt_mod #(.W(PH_W)) u_ph (
        .clk  (clk),
        .rst  (rst),
        .clr  (go || st == CLEAR),
        .en   (in_run && !abort),
        .term (PH_W'(FWD_LAT)),
        .q    (ph_q),
        .tc   (ph_tc)
    );

    cnt_mod #(.W(ADDR_W + 1)) u_bat (
        .clk  (clk),
        .rst  (rst),
        .clr  (go || st == CLEAR),
        .en   (accu_i && !abort),
        .term (n_batch - (ADDR_W + 1)'(1)),
        .q    (b_q),
        .tc   (b_tc)
    );

    // wraps to 0 after the last sample, which also marks epoch end
    cnt_mod #(.W(ADDR_W + 1)) u_smp (
        .clk  (clk),
        .rst  (rst),
        .clr  (go),
        .en   (accu_i && !abort),
        .term (n_smpl - (ADDR_W + 1)'(1)),
        .q    (s_q),
        .tc   (s_tc)
    );

    assign o_addr   = s_q[ADDR_W-1:0];
    assign load     = in_run && (ph_q == PH_W'(LOAD_OFS));
    assign accu     = accu_i;
    assign smpl_vld = accu_i;
    assign wr       = (st == UPDATE);
    assign rst_btch = (st == CLEAR);
    assign done     = (st == DONE);
    assign busy     = (st != IDLE);
    assign o_epoch  = epoch;

endmodule
